wb_commit: RTL and testbench

Parametrised writeback/commit stage for the pipelined LC-3b core, successor to the single-cycle writeback block. It holds one retiring instruction and waits any number of cycles for a load response before committing. It then drives the register-file write port, updates the NZP condition codes, and counts retired instructions. It sits between the EX/MEM pipeline register (valid/ready handshake) and the ID-stage register file, and reports its pending destination register to the hazard unit.

---
 rtl/wb_commit_pkg.sv | 28 ++
 rtl/wb_commit_gencc.sv | 27 ++
 rtl/wb_commit.sv | 184 ++++++++++++++++++
 tb/tb_wb_commit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_commit_pkg.sv
// -----------------------------------------------------------------------------
// wb_commit_pkg
//   Shared types and constants for the LC-3b writeback/commit stage.
//   - wb_data_sel_t : source select for the register-file write data
//   - wb_state_t    : commit-stage FSM states
//   - lc3b_nzp      : {n,z,p} condition-code vector
//   - NZP_RESET     : condition codes after reset (Z set)
// -----------------------------------------------------------------------------
package wb_commit_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_MEM  = 2'b01,
        WB_PC   = 2'b10,
        WB_ZERO = 2'b11
    } wb_data_sel_t;

    typedef enum logic [1:0] {
        EMPTY    = 2'b00,
        WAIT_MEM = 2'b01,
        READY    = 2'b10
    } wb_state_t;

    typedef logic [2:0] lc3b_nzp;

    localparam lc3b_nzp NZP_RESET = 3'b010;

endpackage

// File: rtl/wb_commit_gencc.sv
// -----------------------------------------------------------------------------
// gencc_n
//   Combinational NZP generator for a WIDTH-bit value. Exactly one output bit
//   is set: n for a negative value, z for zero, p otherwise.
//   Ports:
//     data  in  WIDTH  value to classify
//     nzp   out 3      {n,z,p}
// -----------------------------------------------------------------------------
module gencc_n
    import wb_commit_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] data,
    output lc3b_nzp          nzp
);

    logic is_neg;
    logic is_zero;

    assign is_neg  = data[WIDTH-1];
    assign is_zero = (data == '0);

    // Zero has a clear sign bit, so n and z can never both be set.
    assign nzp = {is_neg, is_zero, ~is_neg & ~is_zero};

endmodule

// File: rtl/wb_commit.sv
// -----------------------------------------------------------------------------
// wb_commit
//   Writeback/commit stage. Holds one retiring instruction, waits for a load
//   response when needed, then writes the register file, updates NZP and
//   counts retired instructions.
//   Ports:
//     clk, reset                     clock, synchronous active-high reset
//     in_valid / in_ready            upstream handshake
//     in_inst, in_pc, in_alu         instruction, PC, ALU result
//     in_reg_load, in_dest_sel       write enable, destination select
//     in_data_sel, in_load_cc        write-data source, NZP update enable
//     in_mem_read                    entry waits for mem_resp
//     mem_resp, mem_rdata            load response
//     reg_load, reg_dest, reg_data   register-file write port
//     cc_out                         NZP register
//     pend_valid, pend_dest          pending destination for hazard unit
//     retired                        committed-instruction count
// -----------------------------------------------------------------------------
module wb_commit
    import wb_commit_pkg::*;
#(
    parameter int                  WIDTH    = 16,
    parameter int                  REG_BITS = 3,
    parameter int                  DEST_LSB = 9,
    parameter logic [REG_BITS-1:0] LINK_REG = {REG_BITS{1'b1}},
    parameter int                  CNT_BITS = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_inst,
    input  logic [WIDTH-1:0]    in_pc,
    input  logic [WIDTH-1:0]    in_alu,
    input  logic                in_reg_load,
    input  logic                in_dest_sel,
    input  wb_data_sel_t        in_data_sel,
    input  logic                in_load_cc,
    input  logic                in_mem_read,
    input  logic                mem_resp,
    input  logic [WIDTH-1:0]    mem_rdata,
    output logic                reg_load,
    output logic [REG_BITS-1:0] reg_dest,
    output logic [WIDTH-1:0]    reg_data,
    output lc3b_nzp             cc_out,
    output logic                pend_valid,
    output logic [REG_BITS-1:0] pend_dest,
    output logic [CNT_BITS-1:0] retired
);

    wb_state_t state_reg;
    wb_state_t state_next;

    // Holding register for the retiring entry.
    logic                load_reg;
    logic [REG_BITS-1:0] dest_reg;
    logic [WIDTH-1:0]    pc_reg;
    logic [WIDTH-1:0]    alu_reg;
    logic [WIDTH-1:0]    mem_data_reg;
    wb_data_sel_t        data_sel_reg;
    logic                load_cc_reg;

    lc3b_nzp             cc_reg;
    lc3b_nzp             cc_next;
    logic [CNT_BITS-1:0] retired_reg;

    logic accept;
    logic commit;

    // Only the destination field of the instruction matters here; the rest
    // is folded into a deliberately unused signal.
    logic unused_inst;
    assign unused_inst = ^in_inst;

    assign in_ready = (state_reg != WAIT_MEM);
    assign accept   = in_valid && in_ready;
    assign commit   = (state_reg == READY);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            EMPTY, READY: begin
                // READY always commits this cycle, so it refills exactly like
                // EMPTY does; with no new entry it drains to EMPTY.
                if (accept) begin
                    state_next = in_mem_read ? WAIT_MEM : READY;
                end else begin
                    state_next = EMPTY;
                end
            end
            WAIT_MEM: begin
                if (mem_resp) begin
                    state_next = READY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    // ----------------------------------------------------- holding register
    always_ff @(posedge clk) begin
        if (reset) begin
            load_reg     <= 1'b0;
            dest_reg     <= '0;
            pc_reg       <= '0;
            alu_reg      <= '0;
            mem_data_reg <= '0;
            data_sel_reg <= WB_ALU;
            load_cc_reg  <= 1'b0;
        end else if (accept) begin
            load_reg     <= in_reg_load;
            dest_reg     <= in_dest_sel ? LINK_REG : in_inst[DEST_LSB +: REG_BITS];
            pc_reg       <= in_pc;
            alu_reg      <= in_alu;
            mem_data_reg <= '0;
            data_sel_reg <= in_data_sel;
            load_cc_reg  <= in_load_cc;
        end else if ((state_reg == WAIT_MEM) && mem_resp) begin
            // Responses outside WAIT_MEM are stray and never captured.
            mem_data_reg <= mem_rdata;
        end
    end

    // --------------------------------------------------- commit write port
    always_comb begin
        reg_load = 1'b0;
        reg_dest = '0;
        reg_data = '0;
        if (commit) begin
            reg_load = load_reg;
            reg_dest = dest_reg;
            case (data_sel_reg)
                WB_ALU:  reg_data = alu_reg;
                WB_MEM:  reg_data = mem_data_reg;
                WB_PC:   reg_data = pc_reg;
                WB_ZERO: reg_data = '0;
                default: reg_data = '0;
            endcase
        end
    end

    assign pend_valid = (state_reg != EMPTY) && load_reg;
    assign pend_dest  = (state_reg != EMPTY) ? dest_reg : '0;

    // --------------------------------------------------- condition codes
    gencc_n #(
        .WIDTH(WIDTH)
    ) u_gencc (
        .data(reg_data),
        .nzp (cc_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            cc_reg <= NZP_RESET;
        end else if (commit && load_cc_reg) begin
            cc_reg <= cc_next;
        end
    end

    assign cc_out = cc_reg;

    // --------------------------------------------------- retired counter
    // Counts every commit, writing or not; wraps naturally at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            retired_reg <= '0;
        end else if (commit) begin
            retired_reg <= retired_reg + 1'b1;
        end
    end

    assign retired = retired_reg;

endmodule

// File: tb/tb_wb_commit.sv
// -----------------------------------------------------------------------------
// tb_wb_commit
//   Directed self-checking bench for wb_commit with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_wb_commit;
    import wb_commit_pkg::*;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [15:0]   in_inst;
    logic [15:0]   in_pc;
    logic [15:0]   in_alu;
    logic          in_reg_load;
    logic          in_dest_sel;
    wb_data_sel_t  in_data_sel;
    logic          in_load_cc;
    logic          in_mem_read;
    logic          mem_resp;
    logic [15:0]   mem_rdata;
    logic          reg_load;
    logic [2:0]    reg_dest;
    logic [15:0]   reg_data;
    lc3b_nzp       cc_out;
    logic          pend_valid;
    logic [2:0]    pend_dest;
    logic [31:0]   retired;

    int n_checks = 0;
    int n_errors = 0;

    wb_commit dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_inst    (in_inst),
        .in_pc      (in_pc),
        .in_alu     (in_alu),
        .in_reg_load(in_reg_load),
        .in_dest_sel(in_dest_sel),
        .in_data_sel(in_data_sel),
        .in_load_cc (in_load_cc),
        .in_mem_read(in_mem_read),
        .mem_resp   (mem_resp),
        .mem_rdata  (mem_rdata),
        .reg_load   (reg_load),
        .reg_dest   (reg_dest),
        .reg_data   (reg_data),
        .cc_out     (cc_out),
        .pend_valid (pend_valid),
        .pend_dest  (pend_dest),
        .retired    (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Advance one cycle; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_entry(input logic [15:0] inst, input logic [15:0] pc,
                               input logic [15:0] alu, input logic rl,
                               input logic ds, input wb_data_sel_t sel,
                               input logic lcc, input logic mr);
        in_valid    = 1'b1;
        in_inst     = inst;
        in_pc       = pc;
        in_alu      = alu;
        in_reg_load = rl;
        in_dest_sel = ds;
        in_data_sel = sel;
        in_load_cc  = lcc;
        in_mem_read = mr;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_in_ready"},   {31'd0, in_ready},   32'd1);
        check({pfx, "_reg_load"},   {31'd0, reg_load},   32'd0);
        check({pfx, "_reg_dest"},   {29'd0, reg_dest},   32'd0);
        check({pfx, "_reg_data"},   {16'd0, reg_data},   32'd0);
        check({pfx, "_cc_out"},     {29'd0, cc_out},     32'd2);
        check({pfx, "_pend_valid"}, {31'd0, pend_valid}, 32'd0);
        check({pfx, "_pend_dest"},  {29'd0, pend_dest},  32'd0);
        check({pfx, "_retired"},    retired,             32'd0);
    endtask

    initial begin
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_inst     = '0;
        in_pc       = '0;
        in_alu      = '0;
        in_reg_load = 1'b0;
        in_dest_sel = 1'b0;
        in_data_sel = WB_ALU;
        in_load_cc  = 1'b0;
        in_mem_read = 1'b0;
        mem_resp    = 1'b0;
        mem_rdata   = '0;

        tick();
        tick();
        check_reset_outputs("rst");
        reset = 1'b0;

        // 1: ALU entry, dest field 3, negative result
        drive_entry(16'h0600, 16'h0000, 16'h8000, 1'b1, 1'b0, WB_ALU, 1'b1, 1'b0);
        tick();
        in_valid = 1'b0;
        check("alu_reg_load",   {31'd0, reg_load},   32'd1);
        check("alu_reg_dest",   {29'd0, reg_dest},   32'd3);
        check("alu_reg_data",   {16'd0, reg_data},   32'h8000);
        check("alu_pend_valid", {31'd0, pend_valid}, 32'd1);
        check("alu_pend_dest",  {29'd0, pend_dest},  32'd3);
        tick();
        check("alu_cc",         {29'd0, cc_out},     32'b100);
        check("alu_retired",    retired,             32'd1);
        check("alu_drained",    {31'd0, reg_load},   32'd0);

        // 2: load entry, dest field 5, response after 4 waiting cycles
        drive_entry(16'h0A00, 16'h0000, 16'h1234, 1'b1, 1'b0, WB_MEM, 1'b1, 1'b1);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ld_wait%0d_ready", i),     {31'd0, in_ready},   32'd0);
            check($sformatf("ld_wait%0d_pend", i),      {31'd0, pend_valid}, 32'd1);
            check($sformatf("ld_wait%0d_pend_dest", i), {29'd0, pend_dest},  32'd5);
            check($sformatf("ld_wait%0d_reg_load", i),  {31'd0, reg_load},   32'd0);
            if (i == 3) begin
                mem_resp  = 1'b1;
                mem_rdata = 16'h0000;
            end
            tick();
        end
        mem_resp  = 1'b0;
        mem_rdata = 16'hBEEF;
        check("ld_reg_load", {31'd0, reg_load}, 32'd1);
        check("ld_reg_dest", {29'd0, reg_dest}, 32'd5);
        check("ld_reg_data", {16'd0, reg_data}, 32'h0000);
        tick();
        check("ld_cc",       {29'd0, cc_out},   32'b010);
        check("ld_retired",  retired,           32'd2);

        // 3: JSR link write, no CC update
        drive_entry(16'h0400, 16'h3002, 16'hFFFF, 1'b1, 1'b1, WB_PC, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        check("jsr_reg_dest", {29'd0, reg_dest}, 32'd7);
        check("jsr_reg_data", {16'd0, reg_data}, 32'h3002);
        tick();
        check("jsr_cc",       {29'd0, cc_out},   32'b010);
        check("jsr_retired",  retired,           32'd3);

        // 4: ten back-to-back ALU entries
        for (int i = 0; i < 10; i++) begin
            check($sformatf("b2b%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
            drive_entry(16'((i % 8) << 9), 16'h0000, 16'(i + 1), 1'b1, 1'b0, WB_ALU, 1'b1, 1'b0);
            tick();
            check($sformatf("b2b%0d_reg_load", i), {31'd0, reg_load}, 32'd1);
            check($sformatf("b2b%0d_reg_dest", i), {29'd0, reg_dest}, 32'(i % 8));
            check($sformatf("b2b%0d_reg_data", i), {16'd0, reg_data}, 32'(i + 1));
        end
        in_valid = 1'b0;
        tick();
        check("b2b_retired",  retired,           32'd13);
        check("b2b_cc",       {29'd0, cc_out},   32'b001);
        check("b2b_drained",  {31'd0, reg_load}, 32'd0);

        // 5: stray response while EMPTY, then reset during WAIT_MEM
        mem_resp  = 1'b1;
        mem_rdata = 16'hFFFF;
        tick();
        mem_resp  = 1'b0;
        check("stray_reg_load", {31'd0, reg_load}, 32'd0);
        check("stray_retired",  retired,           32'd13);
        check("stray_cc",       {29'd0, cc_out},   32'b001);
        drive_entry(16'h0200, 16'h0000, 16'h0000, 1'b1, 1'b0, WB_MEM, 1'b1, 1'b1);
        tick();
        in_valid = 1'b0;
        check("mid_in_ready", {31'd0, in_ready}, 32'd0);
        reset     = 1'b1;
        mem_resp  = 1'b1;
        mem_rdata = 16'h8000;
        tick();
        reset    = 1'b0;
        mem_resp = 1'b0;
        check_reset_outputs("mid_rst");
        tick();
        check("post_rst_reg_load", {31'd0, reg_load}, 32'd0);
        check("post_rst_retired",  retired,           32'd0);
        check("post_rst_cc",       {29'd0, cc_out},   32'b010);

        // 6: counter wrap
        force dut.retired_reg = 32'hFFFF_FFFF;
        #1;
        release dut.retired_reg;
        check("wrap_preload", retired, 32'hFFFF_FFFF);
        drive_entry(16'h0000, 16'h0000, 16'h0001, 1'b0, 1'b0, WB_ALU, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        check("wrap_commit_no_write", {31'd0, reg_load}, 32'd0);
        tick();
        check("wrap_retired", retired, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
